// File: rtl/qpp_addr_gen.sv
// LTE turbo-interleaver QPP address generator, Pi(i) = (f1*i + f2*i^2) mod K.
// Define ERR_CHK_EN to enable parameter checking at start (err output).
module qpp_addr_gen #(
    parameter int KW  = 13,
    parameter int F1W = 9,
    parameter int F2W = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic [F1W-1:0] f1,
    input  logic [F2W-1:0] f2,
    output logic [KW-1:0] addr,
    output logic          addr_valid,
    input  logic          addr_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN
    } state_e;

    state_e        state_q;
    logic [KW-1:0] k_q;
    logic [F1W-1:0] f1_q;
    logic [F2W-1:0] f2_q;
    logic [KW-1:0] pi_q;
    logic [KW-1:0] g_q;
    logic [KW-1:0] d2_q;
    logic [KW-1:0] i_q;
    logic          addr_valid_q;
    logic          busy_q;
    logic          done_q;

    logic [KW:0]   k_ext;
    logic [KW:0]   sum_pi;
    logic [KW:0]   sum_g;
    logic [KW:0]   sum_init;
    logic [KW:0]   sum_d2;
    logic [KW:0]   red_pi;
    logic [KW:0]   red_g;
    logic [KW:0]   red_init;
    logic [KW:0]   red_d2;
    logic [KW-1:0] pi_d;
    logic [KW-1:0] g_d;
    logic [KW-1:0] g_init_d;
    logic [KW-1:0] d2_init_d;
    logic          last_d;

    // Every modulo is one conditional subtract; operands are assumed < K.
    always_comb begin
        k_ext     = {1'b0, k_q};
        sum_pi    = {1'b0, pi_q} + {1'b0, g_q};
        sum_g     = {1'b0, g_q} + {1'b0, d2_q};
        sum_init  = {{(KW+1-F1W){1'b0}}, f1_q}
                  + {{(KW+1-F2W){1'b0}}, f2_q};
        sum_d2    = {{(KW-F2W){1'b0}}, f2_q, 1'b0};
        red_pi    = (sum_pi >= k_ext) ? sum_pi - k_ext : sum_pi;
        red_g     = (sum_g >= k_ext) ? sum_g - k_ext : sum_g;
        red_init  = (sum_init >= k_ext) ? sum_init - k_ext : sum_init;
        red_d2    = (sum_d2 >= k_ext) ? sum_d2 - k_ext : sum_d2;
        pi_d      = red_pi[KW-1:0];
        g_d       = red_g[KW-1:0];
        g_init_d  = red_init[KW-1:0];
        d2_init_d = red_d2[KW-1:0];
        // K=0 and K=1 both end after the first address.
        last_d    = ({1'b0, i_q} + (KW+1)'(1)) >= k_ext;
    end

`ifdef ERR_CHK_EN
    logic err_q;
    logic param_bad;

    always_comb begin
        param_bad = (k_len < KW'(40))
                 || (k_len > KW'(6144))
                 || k_len[0]
                 || (KW'(f1) >= k_len)
                 || (KW'(f2) >= k_len)
                 || !f1[0];
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            f1_q         <= '0;
            f2_q         <= '0;
            pi_q         <= '0;
            g_q          <= '0;
            d2_q         <= '0;
            i_q          <= '0;
            addr_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef ERR_CHK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
`ifdef ERR_CHK_EN
                        if (param_bad) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b0;
                            k_q     <= k_len;
                            f1_q    <= f1;
                            f2_q    <= f2;
                            busy_q  <= 1'b1;
                            state_q <= INIT;
                        end
`else
                        k_q     <= k_len;
                        f1_q    <= f1;
                        f2_q    <= f2;
                        busy_q  <= 1'b1;
                        state_q <= INIT;
`endif
                    end
                end
                INIT: begin
                    g_q          <= g_init_d;
                    d2_q         <= d2_init_d;
                    pi_q         <= '0;
                    i_q          <= '0;
                    addr_valid_q <= 1'b1;
                    state_q      <= RUN;
                end
                RUN: begin
                    if (addr_ready) begin
                        if (last_d) begin
                            addr_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            pi_q <= pi_d;
                            g_q  <= g_d;
                            i_q  <= i_q + KW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr       = pi_q;
    assign addr_valid = addr_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
